prng_share_ctrl: RTL and testbench
==================================

Name: prng_share_ctrl

Overview:
- Sequences a shared PRNG core and time-shares it between N_REQ requesters (e.g. several dice/display lanes).
- Owns seeding from a free-running counter, round-robin arbitration, and a req/ack handshake that returns one fresh random number per grant.
- Sits between the lane FSMs and the PRNG core, and drives the core's set-seed, generate and seed inputs.

Parameters:
N_REQ, 4, number of requesters (2..8)
SEED_W, 16, PRNG seed width
NUM_W, 4, PRNG output width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  N_REQ  per-requester request level; held until matching ack
i_reseed  in  1  single-cycle pulse; reseed the PRNG before the next grant
o_ack  out  N_REQ  one-hot, single-cycle; o_rnd valid in the same cycle
o_rnd  out  NUM_W  random number for the acked requester (registered)
o_seeded  out  1  high once the PRNG has been seeded since reset
o_prng_set_seed  out  1  to PRNG: load seed this cycle
o_prng_seed  out  SEED_W  to PRNG: seed value
o_prng_gen  out  1  to PRNG: advance this cycle
i_prng_num  in  NUM_W  from PRNG: current output

Behaviour:
- Reset (async, i_rst_n low):
  - state=S_UNSEEDED, ptr=0, seed_cnt=0.
  - o_ack=0, o_rnd=0, o_seeded=0.
  - o_prng_set_seed=0, o_prng_gen=0.
  - Reset mid-transaction aborts it and no ack is issued.
- seed_cnt: SEED_W-bit counter that increments every cycle out of reset and wraps. o_prng_seed=seed_cnt combinationally.
- S_UNSEEDED: if |i_req or i_reseed then go to S_SEED.
- S_SEED:
  - o_prng_set_seed=1 for exactly this cycle; the seed is seed_cnt's value in this cycle.
  - o_seeded<=1. Next state S_ARB.
- S_ARB:
  - Eligible mask = i_req & ~o_ack. The just-acked requester is excluded in its ack cycle so it cannot be re-granted.
  - If i_reseed: go to S_SEED with no grant (reseed wins over requests).
  - Else if any eligible request:
    - Winner = first eligible index scanning ptr, ptr+1, ... with wrap modulo N_REQ.
    - o_prng_gen=1 this cycle. Latch win_idx. Next state S_WAIT.
  - Else stay in S_ARB.
- S_WAIT:
  - i_prng_num reflects the advanced PRNG state.
  - o_rnd<=i_prng_num; o_ack<=onehot(win_idx); ptr<=(win_idx+1) mod N_REQ. Next state S_ARB.
- Latency and throughput:
  - Grant (gen) in cycle T; ack and o_rnd valid in cycle T+2.
  - From reset, a request first sampled in cycle 0 yields S_SEED in cycle 1, gen in cycle 2, ack in cycle 4.
  - Peak throughput is one number per 2 cycles.
- o_ack is high for exactly one cycle. o_rnd holds its value until the next ack.
- i_reseed during S_WAIT or S_SEED is latched into a pending flag. The current transaction completes, then S_ARB goes to S_SEED. The pending flag clears on entering S_SEED.
- Request dropped after grant: the transaction still completes and the ack pulses anyway; the requester ignores it.
- o_prng_set_seed and o_prng_gen are never high in the same cycle.
- o_prng_gen is never high while o_seeded=0.

Decomposition:
- Package prng_share_pkg:
  - state enum {S_UNSEEDED, S_SEED, S_ARB, S_WAIT}
  - default width constants NUM_W=4, SEED_W=16
- Sub-module rr_pick: combinational round-robin find-first over N_REQ with rotating pointer. Outputs valid and index.

Test Plan:
- Seeding: reset, hold i_req=4'b0100 with the request first sampled when seed_cnt=100.
  - Required: set_seed pulse with o_prng_seed=16'd101, gen one cycle later, o_ack=4'b0100 two cycles after gen.
  - o_rnd equals the PRNG output after one step from that seed.
- Round-robin: after seeding, hold i_req=4'b1111, each requester dropping its request the cycle after its ack.
  - Required: ack order 0001, 0010, 0100, 1000, with acks every 2 cycles.
- Single-requester no double grant: i_req=4'b0001 held for one cycle after the ack.
  - Required: exactly one gen pulse and one ack.
- Wrap priority: ptr=3 (last winner 2), i_req=4'b1001.
  - Required: requester 3 granted first, then requester 0. Next ptr=1.
- Reseed collision:
  - Pulse i_reseed during S_WAIT. Required: the pending ack completes, then set_seed pulses, then the next gen.
  - Pulse i_reseed and i_req together in S_ARB. Required: set_seed occurs before gen.
- Async reset in S_WAIT.
  - Required: o_ack stays 0, o_seeded=0, state returns to S_UNSEEDED, seed_cnt=0.
  - A subsequent request re-seeds before any gen.

Source files
------------

// File: rtl/prng_share_ctrl_pkg.sv
// Shared constants for the PRNG share controller: default widths and the
// controller's FSM state encoding.
package prng_share_pkg;

   localparam int DEF_N_REQ  = 4;
   localparam int DEF_SEED_W = 16;
   localparam int DEF_NUM_W  = 4;

   typedef logic [1:0] state_t;

   // Encoded as plain constants so older tools and scripts can match them.
   localparam state_t S_UNSEEDED = 2'd0;
   localparam state_t S_SEED     = 2'd1;
   localparam state_t S_ARB      = 2'd2;
   localparam state_t S_WAIT     = 2'd3;

endpackage

// File: rtl/prng_share_ctrl_if.sv
// Bundle of the requester-side handshake and the PRNG core connection.
// master = the share controller, slave = requesters plus PRNG core.
interface prng_share_ctrl_if
   import prng_share_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int SEED_W = DEF_SEED_W,
   parameter int NUM_W  = DEF_NUM_W
) ();

   logic [N_REQ-1:0]  req;
   logic              reseed;
   logic [N_REQ-1:0]  ack;
   logic [NUM_W-1:0]  rnd;
   logic              seeded;
   logic              prng_set_seed;
   logic [SEED_W-1:0] prng_seed;
   logic              prng_gen;
   logic [NUM_W-1:0]  prng_num;

   modport master (
      input  req, reseed, prng_num,
      output ack, rnd, seeded, prng_set_seed, prng_seed, prng_gen
   );

   modport slave (
      output req, reseed, prng_num,
      input  ack, rnd, seeded, prng_set_seed, prng_seed, prng_gen
   );

endinterface

// File: rtl/prng_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning from ptr
// upward with wrap-around. idx is meaningful only when valid is high.
module rr_pick
   import prng_share_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   logic             valid_s;
   logic [IDX_W-1:0] idx_s;
   logic [IDX_W-1:0] pos_idx_s;

   // Scan from the farthest offset down to ptr so the nearest hit overwrites.
   always_comb begin
      valid_s   = 1'b0;
      idx_s     = {IDX_W{1'b0}};
      pos_idx_s = {IDX_W{1'b0}};
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos_idx_s = IDX_W'((int'(ptr) + k) % N_REQ);
         valid_s   = valid_s | req[pos_idx_s];
         idx_s     = req[pos_idx_s] ? pos_idx_s : idx_s;
      end
   end

   assign valid = valid_s;
   assign idx   = idx_s;

endmodule

// File: rtl/prng_share_ctrl.sv
// Time-shares one PRNG core between N_REQ requesters: seeds it from a
// free-running counter, arbitrates round-robin, and returns one fresh number
// per grant with a single-cycle one-hot ack.
module prng_share_ctrl
   import prng_share_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int SEED_W = DEF_SEED_W,
   parameter int NUM_W  = DEF_NUM_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   prng_share_ctrl_if.master bus
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [SEED_W-1:0] seed_cnt_r;
   logic [IDX_W-1:0]  ptr_r;
   logic [IDX_W-1:0]  win_idx_r;
   logic [IDX_W-1:0]  pick_idx_s;
   logic [IDX_W-1:0]  ptr_nxt_s;
   logic              pick_valid_s;
   logic              pend_r;
   logic              gen_s;
   logic              set_seed_s;
   logic [N_REQ-1:0]  elig_s;
   logic [N_REQ-1:0]  ack_r;
   logic [N_REQ-1:0]  ack_nxt_s;
   logic [NUM_W-1:0]  rnd_r;
   logic              seeded_r;

   // The requester being acked this cycle still has req high; keep it out.
   assign elig_s    = bus.req & ~ack_r;
   assign ack_nxt_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_r;
   assign ptr_nxt_s = (win_idx_r == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}}
                                                       : win_idx_r + IDX_W'(1);

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req   (elig_s),
      .ptr   (ptr_r),
      .valid (pick_valid_s),
      .idx   (pick_idx_s)
   );

   // Next-state logic and decode of the PRNG load/advance strobes.
   always_comb begin
      state_nxt_s = state_r;
      set_seed_s  = 1'b0;
      gen_s       = 1'b0;
      case (state_r)
         S_UNSEEDED: begin
            if ((|bus.req) || bus.reseed) begin
               state_nxt_s = S_SEED;
            end else begin
               state_nxt_s = S_UNSEEDED;
            end
         end
         S_SEED: begin
            set_seed_s  = 1'b1;
            state_nxt_s = S_ARB;
         end
         S_ARB: begin
            // A reseed (new or deferred) is served before any further grant.
            if (bus.reseed || pend_r) begin
               state_nxt_s = S_SEED;
            end else if (pick_valid_s) begin
               gen_s       = 1'b1;
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_ARB;
            end
         end
         S_WAIT: begin
            state_nxt_s = S_ARB;
         end
         default: begin
            state_nxt_s = S_UNSEEDED;
         end
      endcase
   end

   // Free-running seed source, wraps naturally.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         seed_cnt_r <= {SEED_W{1'b0}};
      end else begin
         seed_cnt_r <= seed_cnt_r + SEED_W'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= S_UNSEEDED;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Defer a reseed that arrives while a seed or a transaction is in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pend_r <= 1'b0;
      end else if (bus.reseed && ((state_r == S_SEED) || (state_r == S_WAIT))) begin
         pend_r <= 1'b1;
      end else if (state_nxt_s == S_SEED) begin
         pend_r <= 1'b0;
      end else begin
         pend_r <= pend_r;
      end
   end

   // Remember who won so the ack lands on the right lane.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         win_idx_r <= {IDX_W{1'b0}};
      end else if (gen_s) begin
         win_idx_r <= pick_idx_s;
      end else begin
         win_idx_r <= win_idx_r;
      end
   end

   // Complete the transaction: capture the advanced PRNG output, pulse ack,
   // and move the round-robin pointer past the winner.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ack_r <= {N_REQ{1'b0}};
         rnd_r <= {NUM_W{1'b0}};
         ptr_r <= {IDX_W{1'b0}};
      end else if (state_r == S_WAIT) begin
         ack_r <= ack_nxt_s;
         rnd_r <= bus.prng_num;
         ptr_r <= ptr_nxt_s;
      end else begin
         ack_r <= {N_REQ{1'b0}};
         rnd_r <= rnd_r;
         ptr_r <= ptr_r;
      end
   end

   // Sticky flag: PRNG has been loaded at least once since reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         seeded_r <= 1'b0;
      end else if (state_r == S_SEED) begin
         seeded_r <= 1'b1;
      end else begin
         seeded_r <= seeded_r;
      end
   end

   assign bus.ack           = ack_r;
   assign bus.rnd           = rnd_r;
   assign bus.seeded        = seeded_r;
   assign bus.prng_set_seed = set_seed_s;
   assign bus.prng_gen      = gen_s;
   assign bus.prng_seed     = seed_cnt_r;

endmodule

// File: tb/tb_prng_share_ctrl.sv
// Directed, table-driven bench for prng_share_ctrl. A stand-in PRNG core
// (next = state*5+3, output = low nibble) feeds the controller.
module tb_prng_share_ctrl;

   localparam int N_REQ  = 4;
   localparam int SEED_W = 16;
   localparam int NUM_W  = 4;

   typedef struct packed {
      logic [3:0] req;
      logic       reseed;
      logic [3:0] ack;
      logic       ss;
      logic       gen;
      logic       seeded;
      logic [3:0] rnd;
   } vec_t;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic [15:0] prng_state = 16'd0;
   int          total      = 0;
   int          bad        = 0;

   vec_t tbl_a [30];
   vec_t tbl_b [12];

   prng_share_ctrl_if #(.N_REQ(N_REQ), .SEED_W(SEED_W), .NUM_W(NUM_W)) bus ();

   prng_share_ctrl #(
      .N_REQ  (N_REQ),
      .SEED_W (SEED_W),
      .NUM_W  (NUM_W)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Stand-in PRNG core: loads on set_seed, steps on gen.
   always @(posedge clk) begin
      if (bus.prng_set_seed) begin
         prng_state <= bus.prng_seed;
      end else if (bus.prng_gen) begin
         prng_state <= prng_state * 16'd5 + 16'd3;
      end
   end

   assign bus.prng_num = prng_state[3:0];

   function automatic vec_t mk(input logic [3:0] req, input logic reseed,
                               input logic [3:0] ack, input logic ss,
                               input logic gen, input logic seeded,
                               input logic [3:0] rnd);
      vec_t v;
      v.req = req; v.reseed = reseed; v.ack = ack; v.ss = ss;
      v.gen = gen; v.seeded = seeded; v.rnd = rnd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge, settle, then return.
   task automatic drive(input logic [3:0] req, input logic reseed);
      @(negedge clk);
      bus.req    = req;
      bus.reseed = reseed;
      #1;
   endtask

   function automatic logic [10:0] ctl_now();
      return {bus.ack, bus.prng_set_seed, bus.prng_gen, bus.seeded, bus.rnd};
   endfunction

   task automatic apply_vec(input vec_t v, input int cyc, input string tag);
      drive(v.req, v.reseed);
      chk($sformatf("%s_ctl[%0d]", tag, cyc), 32'(ctl_now()),
          32'({v.ack, v.ss, v.gen, v.seeded, v.rnd}));
      chk($sformatf("%s_seed[%0d]", tag, cyc), 32'(bus.prng_seed), 32'(cyc));
   endtask

   initial begin
      bus.req    = 4'b0000;
      bus.reseed = 1'b0;

      // Seeding, wrap priority, single-requester, reseed collisions (cycles 100..129).
      tbl_a[0]  = mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
      tbl_a[1]  = mk(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'h0);
      tbl_a[2]  = mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'h0);
      tbl_a[3]  = mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h0);
      tbl_a[4]  = mk(4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'hC);
      tbl_a[5]  = mk(4'b1001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'hC);
      tbl_a[6]  = mk(4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'hC);
      tbl_a[7]  = mk(4'b1001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 4'hF);
      tbl_a[8]  = mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'hF);
      tbl_a[9]  = mk(4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'hE);
      tbl_a[10] = mk(4'b0011, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'hE);
      tbl_a[11] = mk(4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'hE);
      tbl_a[12] = mk(4'b0011, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 4'h9);
      tbl_a[13] = mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h9);
      tbl_a[14] = mk(4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'h0);
      tbl_a[15] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h0);
      tbl_a[16] = mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'h0);
      tbl_a[17] = mk(4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h0);
      tbl_a[18] = mk(4'b0101, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'h3);
      tbl_a[19] = mk(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'h3);
      tbl_a[20] = mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'h3);
      tbl_a[21] = mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h3);
      tbl_a[22] = mk(4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'h6);
      tbl_a[23] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h6);
      tbl_a[24] = mk(4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h6);
      tbl_a[25] = mk(4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'h6);
      tbl_a[26] = mk(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'h6);
      tbl_a[27] = mk(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h6);
      tbl_a[28] = mk(4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 4'h4);
      tbl_a[29] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h4);

      // Round-robin from ptr=0 right after a reset (cycles 0..11).
      tbl_b[0]  = mk(4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
      tbl_b[1]  = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'h0);
      tbl_b[2]  = mk(4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'h0);
      tbl_b[3]  = mk(4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h0);
      tbl_b[4]  = mk(4'b1111, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'h8);
      tbl_b[5]  = mk(4'b1110, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h8);
      tbl_b[6]  = mk(4'b1110, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 4'hB);
      tbl_b[7]  = mk(4'b1100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'hB);
      tbl_b[8]  = mk(4'b1100, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 4'hA);
      tbl_b[9]  = mk(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'hA);
      tbl_b[10] = mk(4'b1000, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 4'h5);
      tbl_b[11] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'h5);

      // Reset state.
      @(negedge clk);
      #1;
      chk("rst_ctl", 32'(ctl_now()), 32'd0);
      chk("rst_seed", 32'(bus.prng_seed), 32'd0);

      // Release mid-high so the next falling edge lies in cycle 0.
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Idle until the seed counter reaches 100; nothing may fire meanwhile.
      for (int c = 0; c < 100; c++) begin
         drive(4'b0000, 1'b0);
         chk($sformatf("idle_ctl[%0d]", c), 32'(ctl_now()), 32'd0);
         chk($sformatf("idle_seed[%0d]", c), 32'(bus.prng_seed), 32'(c));
      end

      for (int i = 0; i < 30; i++) begin
         apply_vec(tbl_a[i], 100 + i, "seq");
      end

      // Async reset while a transaction is in S_WAIT.
      drive(4'b0001, 1'b0);
      chk("rstw_gen", 32'(bus.prng_gen), 32'd1);
      drive(4'b0001, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rstw_ctl", 32'(ctl_now()), 32'd0);
      chk("rstw_seed", 32'(bus.prng_seed), 32'd0);
      drive(4'b0001, 1'b0);
      chk("rstw_hold_ctl", 32'(ctl_now()), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Re-seed before any gen, then round-robin order 0,1,2,3.
      for (int i = 0; i < 12; i++) begin
         apply_vec(tbl_b[i], i, "rr");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
